// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master) and imem (slave).
// One word request at a time; exactly one in-order response per accepted request.
interface pc_fetch_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output req_valid, output addr, input req_ready, input rsp_valid, input rsp_data);
  modport slave  (input req_valid, input addr, output req_ready, output rsp_valid, output rsp_data);
endinterface

// File: rtl/pc_fetch_stage.sv
// RV32I fetch stage: owns the PC, keeps one imem request outstanding, and presents {pc, instr}
// to decode from a single-entry output register. Redirects reload the PC and flush in-flight work.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pc_fetch_stage_if.master         imem,
  output logic [31:0]              adder_operand_a,
  output logic [31:0]              adder_operand_b,
  input  logic [31:0]              adder_result,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_target,
  input  logic                     stall,
  output logic                     if_valid,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_instr,
  output logic                     fetch_misaligned
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {ISSUE, WAIT_RSP, DRAIN, HALT} state_t;

  state_t            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   req_pc;
  logic              rsp_pending;
  logic              consume;
  logic              out_free;
  logic              req_fire;
  logic              target_ok;

  // Request is only offered when the output register is guaranteed free at response time
  always_comb begin
    consume         = 1'b0;
    out_free        = 1'b0;
    imem.req_valid  = 1'b0;
    imem.addr       = pc_q;
    req_fire        = 1'b0;
    target_ok       = 1'b0;
    adder_operand_a = pc_q;
    adder_operand_b = XLEN'(4);

    consume        = if_valid & ~stall;
    out_free       = ~if_valid | consume;
    imem.req_valid = rst_n & (state_q == ISSUE) & out_free & ~redirect_valid;
    req_fire       = imem.req_valid & imem.req_ready;
    target_ok      = (redirect_target[1:0] == 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ISSUE;
      pc_q             <= RESET_VECTOR;
      req_pc           <= '0;
      rsp_pending      <= 1'b0;
      if_valid         <= 1'b0;
      if_pc            <= '0;
      if_instr         <= NOP;
      fetch_misaligned <= 1'b0;
    end else begin
      if (consume) if_valid <= 1'b0;

      // Tracks an accepted request whose response has not yet come back (matters after HALT)
      if (req_fire)            rsp_pending <= 1'b1;
      else if (imem.rsp_valid) rsp_pending <= 1'b0;

      if (redirect_valid) begin
        if_valid <= 1'b0;
        if (!target_ok) begin
          fetch_misaligned <= 1'b1;
          state_q          <= HALT;
        end else begin
          pc_q             <= redirect_target;
          fetch_misaligned <= 1'b0;
          case (state_q)
            ISSUE:           state_q <= ISSUE;
            WAIT_RSP, DRAIN: state_q <= imem.rsp_valid ? ISSUE : DRAIN;
            HALT:            state_q <= (rsp_pending & ~imem.rsp_valid) ? DRAIN : ISSUE;
            default:         state_q <= ISSUE;
          endcase
        end
      end else begin
        case (state_q)
          ISSUE: begin
            if (req_fire) begin
              req_pc  <= pc_q;
              pc_q    <= adder_result;
              state_q <= WAIT_RSP;
            end
          end
          WAIT_RSP: begin
            if (imem.rsp_valid) begin
              if_valid <= 1'b1;
              if_pc    <= req_pc;
              if_instr <= imem.rsp_data;
              state_q  <= ISSUE;
            end
          end
          DRAIN: begin
            if (imem.rsp_valid) state_q <= ISSUE;
          end
          HALT:    state_q <= HALT;
          default: state_q <= ISSUE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: 1-cycle imem model, queue-based scoreboard for requests and decode output.
module tb_pc_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] adder_operand_a, adder_operand_b, adder_result;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;
  logic        fetch_misaligned;

  logic [31:0] adder2_a, adder2_b, adder2_result;
  logic        redirect2_valid, stall2;
  logic [31:0] redirect2_target;
  logic        if2_valid, misaligned2;
  logic [31:0] if2_pc, if2_instr;

  pc_fetch_stage_if imem ();
  pc_fetch_stage_if imem2 ();

  assign adder_result  = adder_operand_a + 32'd4;
  assign adder2_result = adder2_a + 32'd4;

  pc_fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem),
    .adder_operand_a(adder_operand_a), .adder_operand_b(adder_operand_b), .adder_result(adder_result),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .fetch_misaligned(fetch_misaligned)
  );

  pc_fetch_stage #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem(imem2),
    .adder_operand_a(adder2_a), .adder_operand_b(adder2_b), .adder_result(adder2_result),
    .redirect_valid(redirect2_valid), .redirect_target(redirect2_target), .stall(stall2),
    .if_valid(if2_valid), .if_pc(if2_pc), .if_instr(if2_instr), .fetch_misaligned(misaligned2)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr[$];
  if_t         exp_if[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h00A0_5500;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Memory: answers each accepted request on the following cycle
  logic        pend;
  logic [31:0] pend_addr;
  initial begin
    pend = 1'b0;
    pend_addr = '0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    forever begin
      @(negedge clk);
      imem.rsp_valid = pend;
      imem.rsp_data  = word(pend_addr);
      #4;
      pend      = rst_n && imem.req_valid && imem.req_ready;
      pend_addr = imem.addr;
    end
  end

  // Monitor: pops expectations whenever a request is accepted or decode consumes an instruction
  initial begin
    logic [31:0] ea;
    if_t         ei;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) begin
        if (imem.req_valid && imem.req_ready) begin
          if (exp_addr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got addr %h expected no request", imem.addr);
          end else begin
            ea = exp_addr.pop_front();
            check("req_addr", imem.addr, ea);
          end
        end
        if (if_valid && !stall) begin
          if (exp_if.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_if: got pc %h instr %h expected none", if_pc, if_instr);
          end else begin
            ei = exp_if.pop_front();
            check("if_pc", if_pc, ei.pc);
            check("if_instr", if_instr, ei.instr);
          end
        end
      end
    end
  end

  task automatic push(input logic [31:0] a);
    exp_addr.push_back(a);
    exp_if.push_back({a, word(a)});
  endtask

  task automatic run_until_empty();
    int n;
    n = 0;
    while (exp_addr.size() != 0 && n < 64) begin tick(); n++; end
    imem.req_ready = 1'b0;
    while (exp_if.size() != 0 && n < 64) begin tick(); n++; end
    checks++;
    if (n >= 64) begin
      errors++;
      $display("FAIL drain_timeout: pending addr=%0d if=%0d required 0", exp_addr.size(), exp_if.size());
    end
  endtask

  task automatic reset_dut();
    tick();
    rst_n = 1'b0;
    imem.req_ready = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    tick();
    exp_addr.delete();
    exp_if.delete();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    imem.req_ready = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    imem2.req_ready = 1'b0;
    imem2.rsp_valid = 1'b0;
    imem2.rsp_data = '0;
    redirect2_valid = 1'b0;
    redirect2_target = '0;
    stall2 = 1'b0;
    tick(); tick();
    #4;
    check("rst_req_valid", 32'(imem.req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0000_0013);
    check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
    check("rst_operand_a", adder_operand_a, 32'h0);
    check("rst_operand_b", adder_operand_b, 32'd4);
    check("rst_vector2_addr", imem2.addr, 32'hFFFF_FFFC);

    // Sequential fetch 0,4,8,C
    tick();
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    rst_n = 1'b1;
    #4;
    check("vec2_req_valid", 32'(imem2.req_valid), 32'd1);
    check("vec2_addr", imem2.addr, 32'hFFFF_FFFC);
    run_until_empty();

    // Stall holds the output register and blocks new requests
    reset_dut();
    push(32'h0);
    tick();
    stall = 1'b1;
    tick();
    repeat (3) begin
      #4;
      check("stall_if_valid", 32'(if_valid), 32'd1);
      check("stall_if_pc", if_pc, 32'h0);
      check("stall_if_instr", if_instr, word(32'h0));
      check("stall_no_req", 32'(imem.req_valid), 32'd0);
      tick();
    end
    stall = 1'b0;
    push(32'h4);
    run_until_empty();

    // Redirect while waiting on a response: response dropped, refetch at target
    reset_dut();
    exp_addr.push_back(32'h0);
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    #4 check("redir_no_req", 32'(imem.req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    push(32'h100);
    #4 check("redir_dropped", 32'(if_valid), 32'd0);
    run_until_empty();

    // Misaligned redirect halts fetch; aligned redirect recovers
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h102;
    imem.req_ready = 1'b1;
    #4 check("mis_no_req", 32'(imem.req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    repeat (2) begin
      #4;
      check("mis_flag", 32'(fetch_misaligned), 32'd1);
      check("mis_halt_no_req", 32'(imem.req_valid), 32'd0);
      check("mis_pc_kept", adder_operand_a, 32'h104);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    push(32'h200);
    tick();
    redirect_valid = 1'b0;
    #4 check("mis_flag_clear", 32'(fetch_misaligned), 32'd0);
    run_until_empty();

    // PC wrap at the top of the address space
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    imem.req_ready = 1'b1;
    push(32'hFFFF_FFFC);
    push(32'h0);
    run_until_empty();
    #4 check("wrap_next_pc", adder_operand_a, 32'h4);

    // Memory back-pressure holds the request stable
    tick();
    repeat (4) begin
      #4;
      check("bp_req_valid", 32'(imem.req_valid), 32'd1);
      check("bp_addr", imem.addr, 32'h4);
      check("bp_pc", adder_operand_a, 32'h4);
      tick();
    end
    imem.req_ready = 1'b1;
    push(32'h4);
    run_until_empty();

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
